// File: rtl/l2_msg_out_queue.sv
// l2_msg_out_queue
//   Multi-channel output queue between the L2 controller core and the NoC
//   plane interface. Each of NCH channels owns a DEPTH-entry FIFO; the
//   channel heads are merged onto one output port tagged with a channel id.
//   Arbitration is either pure round-robin or strict priority for channel 0,
//   with round-robin among the remaining channels.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-low reset
//   in_valid   per-channel push request
//   in_ready   per-channel space available (registered count only)
//   in_data    channel i payload at [i*WIDTH +: WIDTH]
//   out_valid  merged output holds a message
//   out_ready  consumer accepts the message
//   out_data   head payload of the granted channel (0 when idle)
//   out_ch     granted channel id (0 when idle)
//   level      per-channel occupancy, channel i at [i*CW +: CW]
module l2_msg_out_queue #(
    parameter int NCH      = 3,
    parameter int DEPTH    = 4,
    parameter int WIDTH    = 64,
    parameter int PRIO_CH0 = 0,
    parameter int CHW      = $clog2(NCH)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NCH-1:0]                       in_valid,
    output logic [NCH-1:0]                       in_ready,
    input  logic [NCH*WIDTH-1:0]                 in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [WIDTH-1:0]                     out_data,
    output logic [CHW-1:0]                       out_ch,
    output logic [NCH*($clog2(DEPTH)+1)-1:0]     level
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0]    count_q [NCH];
    logic [CW-1:0]    count_d [NCH];
    logic [PW-1:0]    wptr_q  [NCH];
    logic [PW-1:0]    wptr_d  [NCH];
    logic [PW-1:0]    rptr_q  [NCH];
    logic [PW-1:0]    rptr_d  [NCH];
    logic [CHW-1:0]   rr_last_q, rr_last_d;
    logic [CHW-1:0]   gnt_q, gnt_d;
    logic             lock_q, lock_d;
    logic [WIDTH-1:0] mem_q [NCH][DEPTH];

    logic [NCH-1:0]   req;
    logic [NCH-1:0]   push;
    logic [NCH-1:0]   pop;
    logic [CHW-1:0]   gnt;
    logic             found;
    logic             hs;

    // Arbitration and output selection, all from registered state.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            req[i]      = (count_q[i] != '0);
            in_ready[i] = (count_q[i] != CW'(DEPTH));
        end
        out_valid = |req;

        if (lock_q) begin
            // A stalled grant is held until its handshake completes.
            gnt   = gnt_q;
            found = 1'b1;
        end else if (PRIO_CH0 != 0 && req[0]) begin
            gnt   = '0;
            found = 1'b1;
        end else begin
            for (int unsigned off = 1; off <= NCH; off++) begin
                idx = 32'(rr_last_q) + off;
                if (idx >= NCH) idx = idx - NCH;
                if (!found && req[CHW'(idx)] && !(PRIO_CH0 != 0 && idx == 0)) begin
                    gnt   = CHW'(idx);
                    found = 1'b1;
                end
            end
        end

        out_ch   = out_valid ? gnt : '0;
        out_data = out_valid ? mem_q[gnt][rptr_q[gnt]] : '0;
        hs       = out_valid && out_ready;
    end

    // Next-state for FIFOs and arbiter.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            push[i]    = in_valid[i] && in_ready[i];
            pop[i]     = hs && (gnt == CHW'(i));
            count_d[i] = count_q[i] + CW'(push[i]) - CW'(pop[i]);
            wptr_d[i]  = wptr_q[i] + PW'(push[i]);
            rptr_d[i]  = rptr_q[i] + PW'(pop[i]);
        end
        lock_d    = out_valid && !out_ready;
        gnt_d     = gnt;
        rr_last_d = rr_last_q;
        if (hs && !(PRIO_CH0 != 0 && gnt == '0)) rr_last_d = gnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                count_q[i] <= '0;
                wptr_q[i]  <= '0;
                rptr_q[i]  <= '0;
            end
            rr_last_q <= CHW'(NCH - 1);
            gnt_q     <= '0;
            lock_q    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                count_q[i] <= count_d[i];
                wptr_q[i]  <= wptr_d[i];
                rptr_q[i]  <= rptr_d[i];
            end
            rr_last_q <= rr_last_d;
            gnt_q     <= gnt_d;
            lock_q    <= lock_d;
        end
    end

    // Payload storage needs no reset: it is only observed through a
    // non-empty count, and idle outputs are forced to zero above.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NCH; i++) begin
            if (push[i]) mem_q[i][wptr_q[i]] <= in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        level = '0;
        for (int unsigned i = 0; i < NCH; i++) level[i*CW +: CW] = count_q[i];
    end

endmodule

// File: doc/l2_msg_out_queue.md
Name: l2_msg_out_queue

Overview:
- Parametrised multi-channel output queue between the L2 controller core and the NoC plane interface. Generalises the flat single-message output ports (req_out, rsp_out, inval, stats) into NCH independently buffered channels.
- Merges the channels onto one shared output port tagged with a channel id.
- Arbitration is either round-robin or fixed-priority (channel 0 first, so coherence responses drain ahead of requests and cannot deadlock behind them).

Parameters:
- NCH, 3, number of input channels (2..8).
- DEPTH, 4, entries per channel FIFO; power of two, ≥2.
- WIDTH, 64, payload bits per message.
- PRIO_CH0, 0, 1 = channel 0 strict priority with round-robin among the rest; 0 = pure round-robin.
- CHW, $clog2(NCH), width of the channel id.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  NCH  per-channel push request.
- in_ready  out  NCH  per-channel space available.
- in_data  in  NCH*WIDTH  channel i payload at bits [i*WIDTH +: WIDTH].
- out_valid  out  1  merged output has a message.
- out_ready  in  1  consumer accepts.
- out_data  out  WIDTH  head payload of the granted channel.
- out_ch  out  CHW  id of the granted channel.
- level  out  NCH*($clog2(DEPTH)+1)  per-channel occupancy.

Behaviour:
- Reset (rst=0, async), all channels:
  - count=0, read/write pointers=0.
  - rr_last=NCH-1, so channel 0 wins the first arbitration.
  - lock=0.
  - Outputs: out_valid=0, out_ch=0, out_data=0, level=0, in_ready=all 1s.
- Per-channel FIFO:
  - in_ready[i] = (count[i] != DEPTH). It is derived only from registered count, with no combinational path from out_ready.
  - Push when in_valid[i] && in_ready[i]: write at wptr, wptr wraps modulo DEPTH.
  - Pop when the channel is granted && out_valid && out_ready: rptr wraps modulo DEPTH.
  - Push and pop in the same cycle on a non-full channel: count unchanged and data order preserved.
  - Full channel: push is refused even if a pop occurs that cycle; the space becomes visible next cycle.
  - Push into an empty channel: visible at the output the next cycle (1-cycle minimum latency). There is no fall-through.
- Arbitration (combinational from registered state):
  - req[i] = (count[i] != 0). out_valid = |req.
  - PRIO_CH0=1 and req[0]: grant channel 0.
  - Otherwise grant the first requesting channel searching from rr_last+1 with wrap-around. With PRIO_CH0=1 the search skips channel 0.
  - Stability: once out_valid=1 && out_ready=0, lock=1 and the current grant is held. out_ch and out_data must not change until the handshake completes, even if a higher-priority channel becomes non-empty.
  - On handshake: lock clears and rr_last becomes the granted channel. In priority mode, a channel-0 grant does not update rr_last.
- When out_valid=0, out_data=0 and out_ch=0. Idle outputs are deterministic.
- level[i] equals count[i] and updates the cycle after a push or pop.
- Reset asserted mid-transfer:
  - All contents are discarded.
  - out_valid drops asynchronously.
  - No message is emitted after reset deasserts until a new push.

Test Plan:
- NCH=3, DEPTH=4: push 4 messages 0xA0..0xA3 on ch0 with out_ready=0 -> in_ready[0]=0 after the 4th push, level[0]=4, a 5th push is refused. Then out_ready=1 -> out_data A0, A1, A2, A3 on out_ch=0, then out_valid=0.
- Preload 2 messages on each of ch0, ch1, ch2, PRIO_CH0=0, out_ready=1 -> out_ch sequence 0,1,2,0,1,2 with one message per cycle.
- PRIO_CH0=1: ch1 and ch2 each hold 2 messages, ch0 receives 1 message mid-stream -> ch0 is granted next (when not locked), then round-robin resumes from the last non-zero channel.
- Ch1 granted with out_ready=0 for 3 cycles while ch0 fills (PRIO_CH0=1) -> out_ch=1 and out_data stable for all 3 cycles. After acceptance, ch0 is granted.
- Ch0 at count=2: simultaneous push of 0x55 and pop -> level[0] stays 2 and FIFO order is preserved. Ch0 full: push together with pop -> push refused, level[0]=3.
- Reset pulsed while ch2 holds 3 messages and out_valid=1 -> out_valid=0 immediately, level=0, in_ready=all 1s. The first post-reset grant goes to the first channel pushed.
